// File: rtl/flop_en_r.sv
// flop_en_r: WIDTH-bit register with a load enable and an asynchronous,
// active-high clear. q is driven straight from the storage bits, so there is
// no combinational path from d or en to q.
module flop_en_r #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Storage: reset clears at once, a load happens on an enabled edge, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= {WIDTH{1'b0}};
    end else if (en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: tb/tb_flop_en_r.sv
// tb_flop_en_r: directed and randomized checks of flop_en_r at widths
// 8, 1, 32 and 64 against a simple "last loaded value or zero" model.
module tb_flop_en_r;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  d8 = 8'h00;
  logic [0:0]  d1 = 1'b0;
  logic [31:0] d32 = 32'h0;
  logic [63:0] d64 = 64'h0;
  logic [7:0]  q8;
  logic [0:0]  q1;
  logic [31:0] q32;
  logic [63:0] q64;

  // Reference: value each register should currently present
  logic [7:0]  m8 = 8'h00;
  logic [0:0]  m1 = 1'b0;
  logic [31:0] m32 = 32'h0;
  logic [63:0] m64 = 64'h0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  flop_en_r #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .en(en), .d(d8),  .q(q8));
  flop_en_r #(.WIDTH(1))  u1  (.clk(clk), .reset(reset), .en(en), .d(d1),  .q(q1));
  flop_en_r #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .en(en), .d(d32), .q(q32));
  flop_en_r #(.WIDTH(64)) u64 (.clk(clk), .reset(reset), .en(en), .d(d64), .q(q64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "/w8"},  {56'h0, q8},  {56'h0, m8});
    chk({tag, "/w1"},  {63'h0, q1},  {63'h0, m1});
    chk({tag, "/w32"}, {32'h0, q32}, {32'h0, m32});
    chk({tag, "/w64"}, q64, m64);
  endtask

  task automatic clear_model();
    m8 = 8'h00; m1 = 1'b0; m32 = 32'h0; m64 = 64'h0;
  endtask

  task automatic set_d(input logic [63:0] v);
    d8 = v[7:0]; d1 = v[0:0]; d32 = v[31:0]; d64 = v;
  endtask

  // One rising edge: apply the register rules to the model, then check 1 time unit later
  task automatic tick(input string tag);
    @(posedge clk);
    if (reset) clear_model();
    else if (en) begin
      m8 = d8; m1 = d1; m32 = d32; m64 = d64;
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    // Reset asserted with en=1 and data present: must clear and stay clear
    en = 1'b1; set_d(64'hA5A5_A5A5_A5A5_A5A5);
    #1 reset = 1'b1;
    #1 clear_model();
    chk_all("rst_async_start");
    repeat (3) tick("rst_hold");

    // Load 3C then raise reset between edges
    reset = 1'b0; en = 1'b1; set_d(64'h3C3C_3C3C_3C3C_3C3C);
    tick("load_3c");
    #2 reset = 1'b1;
    #1 clear_model();
    chk_all("async_rst_midcycle");
    #1 reset = 1'b0; en = 1'b0;

    // Load / hold / load
    en = 1'b1; set_d(64'h5A5A_5A5A_5A5A_5A5A); tick("load_5a");
    en = 1'b0; set_d(64'hFFFF_FFFF_FFFF_FFFF); tick("hold_5a");
    en = 1'b1; tick("load_ff");

    // Reset wins over enable, first edge after release loads
    reset = 1'b1; en = 1'b1; set_d(64'h7777_7777_7777_7777); tick("rst_priority");
    reset = 1'b0; tick("load_after_release");

    // Release with en low keeps zero
    reset = 1'b1; tick("rst_again");
    reset = 1'b0; en = 1'b0; set_d(64'h1234_5678_9ABC_DEF0); tick("release_en_low");

    // Divider-style 1-bit flag usage
    en = 1'b1; d1 = 1'b1; tick("flag_set");
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d1 = 1'(i % 2); set_d({63'h0, 1'(i % 2)}); tick("flag_hold");
    end
    en = 1'b1; set_d(64'h0); tick("flag_clear");

    // Width sweep patterns
    en = 1'b1;
    set_d(64'hFFFF_FFFF_FFFF_FFFF); tick("sweep_ones");
    set_d(64'h5555_5555_5555_5555); tick("sweep_55");
    set_d(64'hAAAA_AAAA_AAAA_AAAA); tick("sweep_aa");
    #2 reset = 1'b1;
    #1 clear_model();
    chk_all("sweep_rst");
    #1 reset = 1'b0;
    set_d(64'hAAAA_AAAA_AAAA_AAAA); tick("sweep_reload");

    // Unknown data with en low must not disturb q
    en = 1'b0; d8 = 8'hxx; d32 = 32'hxxxx_xxxx; tick("x_data_hold");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 19) == 0);
      en = 1'($urandom_range(0, 1));
      set_d({$urandom, $urandom});
      tick("rand");
      if ($urandom_range(0, 15) == 0) begin
        #2 reset = 1'b1;
        #1 clear_model();
        chk_all("rand_async_rst");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
